// File: rtl/io_buffers_pkg.sv
// Shared definitions for the io buffer slice: sequencer state encoding and width helpers.
// Pure declarations; no logic and no latency.
// Imported by the sequencer and by its peer shift buffer in the io wrapper.
package io_buffers_pkg;

  // Sequencer state encoding; the numeric values are visible to the io wrapper and debug taps.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_UNLOAD = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_t;

  // Width of a counter that must be able to hold the value n itself (0..n inclusive).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // True while a frame transfer is in flight.
  function automatic logic state_active(input seq_state_t s);
    return (s == ST_LOAD) || (s == ST_UNLOAD);
  endfunction

endpackage

// File: rtl/io_stream_sequencer.sv
// Sequences one frame of FIFO_SIZE words from an input stream into the peer shift buffer, or out of it.
// Latency: handshake-to-shift is combinational (zero cycles); o_done pulses the cycle after the last handshake.
// Backpressure: i_in_valid / i_out_ready low stalls indefinitely with no shift; i_abort kills the frame.
module io_stream_sequencer
  import io_buffers_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_SIZE  = 256,
  localparam int CW        = cnt_width(FIFO_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // frame control
  input  logic                  i_start_load,
  input  logic                  i_start_unload,
  input  logic                  i_abort,
  // input stream
  input  logic                  i_in_valid,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_in_ready,
  // output stream
  output logic                  o_out_valid,
  output logic [DATA_WIDTH-1:0] o_out_data,
  input  logic                  i_out_ready,
  // shift buffer side
  output logic                  o_shift,
  output logic [DATA_WIDTH-1:0] o_shift_data,
  input  logic [DATA_WIDTH-1:0] i_buf_tail,
  // status
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CW-1:0]         o_count
);

  // Count value at which the next handshake completes the frame.
  localparam logic [CW-1:0] LAST_IDX = CW'(FIFO_SIZE - 1);

  seq_state_t      r_state;
  logic [CW-1:0]   r_count;
  logic            r_done;
  logic            r_busy;

  logic            w_load_open;
  logic            w_unload_open;
  logic            w_load_hs;
  logic            w_unload_hs;
  logic            w_xfer;
  logic            w_last;

  // A transfer window is open only in its state and only when no abort is pending this cycle,
  // so an abort can never let a word slip into or out of the buffer.
  assign w_load_open   = (r_state == ST_LOAD)   && !i_abort;
  assign w_unload_open = (r_state == ST_UNLOAD) && !i_abort;
  assign w_load_hs     = w_load_open   && i_in_valid;
  assign w_unload_hs   = w_unload_open && i_out_ready;
  assign w_xfer        = w_load_hs || w_unload_hs;
  assign w_last        = (r_count == LAST_IDX);

  // Frame state machine: start decode in IDLE, word counting in LOAD/UNLOAD, one-cycle DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Load wins when both requests arrive together; abort is meaningless here.
          if (i_start_load) begin
            r_state <= ST_LOAD;
            r_count <= '0;
            r_busy  <= 1'b1;
          end else if (i_start_unload) begin
            r_state <= ST_UNLOAD;
            r_count <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD, ST_UNLOAD: begin
          if (i_abort) begin
            // Abandon the frame silently; the count is left where it stopped.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_xfer) begin
            r_count <= r_count + CW'(1);
            if (w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          // Count keeps showing FIFO_SIZE until the next start clears it.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Stream handshakes and buffer drive are decoded straight from state so words move with zero latency.
  always_comb begin
    o_in_ready   = w_load_open;
    o_out_valid  = w_unload_open;
    o_shift      = w_xfer;
    o_shift_data = w_load_open ? i_in_data : '0;
    o_out_data   = (r_state == ST_UNLOAD) ? i_buf_tail : '0;
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_count = r_count;

endmodule
